knight_input_ctrl: RTL

KNIGHT_INPUT_CTRL -- requirements
Module: knight_input_ctrl

---
 rtl/knight_pkg.sv | 36 +++
 rtl/frame_counter.sv | 30 +++
 rtl/knight_input_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/knight_pkg.sv
// rtl/knight_pkg.sv - shared key codes, movement encodings and FSM state types for the knight input path
package knight_pkg;

  localparam logic [7:0] HID_NONE  = 8'h00;
  localparam logic [7:0] HID_A     = 8'h04;
  localparam logic [7:0] HID_D     = 8'h07;
  localparam logic [7:0] HID_SPACE = 8'h2C;
  localparam logic [7:0] HID_J     = 8'h0D;

  typedef enum logic [1:0] {
    MOVE_NONE  = 2'b00,
    MOVE_LEFT  = 2'b01,
    MOVE_RIGHT = 2'b10
  } move_e;

  typedef enum logic [1:0] {
    J_IDLE = 2'd0,
    J_BUF  = 2'd1,
    J_HELD = 2'd2
  } jump_state_e;

  typedef enum logic {
    A_READY = 1'b0,
    A_COOL  = 1'b1
  } atk_state_e;

  // Codes the game does not bind collapse to "no key" so they cannot fake a press edge.
  function automatic logic [7:0] key_filter(input logic [7:0] key, input logic [7:0] k_left,
                                            input logic [7:0] k_right, input logic [7:0] k_jump,
                                            input logic [7:0] k_atk);
    if (key == k_left || key == k_right || key == k_jump || key == k_atk)
      return key;
    return HID_NONE;
  endfunction

endpackage

// File: rtl/frame_counter.sv
// rtl/frame_counter.sv - loadable frame down-counter with zero and about-to-expire flags
module frame_counter #(
  parameter int W = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o,
  output logic         last_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);
  // High when the next decrement brings the count to zero.
  assign last_o = (cnt_q == W'(1));

endmodule

// File: rtl/knight_input_ctrl.sv
// rtl/knight_input_ctrl.sv - per-frame keyboard decode into movement, buffered jump and cooled-down attack
module knight_input_ctrl
  import knight_pkg::*;
#(
  parameter int         JUMP_BUF  = 6,
  parameter int         ATK_CD    = 12,
  parameter logic [7:0] KEY_LEFT  = HID_A,
  parameter logic [7:0] KEY_RIGHT = HID_D,
  parameter logic [7:0] KEY_JUMP  = HID_SPACE,
  parameter logic [7:0] KEY_ATK   = HID_J
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       frame_tick,
  input  logic       grounded,
  output logic [1:0] move_dir,
  output logic       face_left,
  output logic       jump_req,
  output logic       jump_hold,
  output logic       attack_req,
  output logic       atk_ready
);

  localparam int JBW = (JUMP_BUF < 1) ? 1 : $clog2(JUMP_BUF + 1);
  localparam int ACW = (ATK_CD < 1) ? 1 : $clog2(ATK_CD + 1);

  logic [7:0]  prev_key_q;
  jump_state_e jst_q, jst_d;
  atk_state_e  ast_q, ast_d;
  move_e       move_q, move_d;
  logic        face_q, face_d;
  logic        jreq_q, jreq_d;
  logic        jhold_q, jhold_d;
  logic        areq_q, areq_d;

  logic [7:0] key_s;
  logic       held_l, held_r, held_j, held_a, press_j, press_a;
  logic       jb_load, jb_dec, jb_zero, jb_last;
  logic       ac_load, ac_dec, ac_zero, ac_last;

  always_comb begin
    key_s   = key_filter(keycode, KEY_LEFT, KEY_RIGHT, KEY_JUMP, KEY_ATK);
    held_l  = (key_s == KEY_LEFT);
    held_r  = (key_s == KEY_RIGHT);
    held_j  = (key_s == KEY_JUMP);
    held_a  = (key_s == KEY_ATK);
    press_j = held_j && (prev_key_q != KEY_JUMP);
    press_a = held_a && (prev_key_q != KEY_ATK);

    move_d = held_l ? MOVE_LEFT : (held_r ? MOVE_RIGHT : MOVE_NONE);
    face_d = held_l ? 1'b1 : (held_r ? 1'b0 : face_q);

    jst_d   = jst_q;
    jreq_d  = 1'b0;
    jb_load = 1'b0;
    jb_dec  = 1'b0;
    case (jst_q)
      J_IDLE: begin
        if (press_j) begin
          if (grounded) begin
            jreq_d = 1'b1;
            jst_d  = J_HELD;
          end else begin
            jb_load = 1'b1;
            jst_d   = J_BUF;
          end
        end
      end
      J_BUF: begin
        // Landing launches only if the key is still down; otherwise the press is discarded.
        if (grounded) begin
          jreq_d = held_j;
          jst_d  = held_j ? J_HELD : J_IDLE;
        end else if (press_j) begin
          jb_load = 1'b1;
        end else begin
          jb_dec = 1'b1;
          if (jb_last || jb_zero) jst_d = J_IDLE;
        end
      end
      J_HELD: begin
        if (!held_j) jst_d = J_IDLE;
      end
      default: jst_d = J_IDLE;
    endcase
    jhold_d = (jst_d == J_HELD) && held_j;

    ast_d   = ast_q;
    areq_d  = 1'b0;
    ac_load = 1'b0;
    ac_dec  = 1'b0;
    case (ast_q)
      A_READY: begin
        if (press_a) begin
          areq_d  = 1'b1;
          ac_load = 1'b1;
          ast_d   = A_COOL;
        end
      end
      default: begin
        ac_dec = 1'b1;
        if (ac_last || ac_zero) ast_d = A_READY;
      end
    endcase
  end

  frame_counter #(.W(JBW)) u_jump_buf (
    .clk_i      (Clk),
    .rst_i      (Reset),
    .load_i     (frame_tick && jb_load),
    .load_val_i (JBW'(JUMP_BUF)),
    .dec_i      (frame_tick && jb_dec),
    .zero_o     (jb_zero),
    .last_o     (jb_last)
  );

  frame_counter #(.W(ACW)) u_atk_cd (
    .clk_i      (Clk),
    .rst_i      (Reset),
    .load_i     (frame_tick && ac_load),
    .load_val_i (ACW'(ATK_CD)),
    .dec_i      (frame_tick && ac_dec),
    .zero_o     (ac_zero),
    .last_o     (ac_last)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      prev_key_q <= HID_NONE;
      jst_q      <= J_IDLE;
      ast_q      <= A_READY;
      move_q     <= MOVE_NONE;
      face_q     <= 1'b0;
      jreq_q     <= 1'b0;
      jhold_q    <= 1'b0;
      areq_q     <= 1'b0;
    end else if (frame_tick) begin
      prev_key_q <= key_s;
      jst_q      <= jst_d;
      ast_q      <= ast_d;
      move_q     <= move_d;
      face_q     <= face_d;
      jreq_q     <= jreq_d;
      jhold_q    <= jhold_d;
      areq_q     <= areq_d;
    end else begin
      jreq_q <= 1'b0;
      areq_q <= 1'b0;
    end
  end

  assign move_dir   = move_q;
  assign face_left  = face_q;
  assign jump_req   = jreq_q;
  assign jump_hold  = jhold_q;
  assign attack_req = areq_q;
  assign atk_ready  = (ast_q == A_READY);

endmodule
